phase_pcie_scheduler: RTL
=========================

PHASE_PCIE_SCHEDULER -- requirements
Module: phase_pcie_scheduler

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): SAMPLES_PER_WORD, 4, 32-bit samples per 128-bit word; BUF_DEPTH, 2, packed-word buffer entries per channel.
REQ-002 Port clk  in  1  single clock; all logic on rising edge.
REQ-003 Port rst  in  1  reset, synchronous, active-high.
REQ-004 Port freq_mode  in  3  0 = single-channel (f1 only), 1 = triple-channel (f1,f2,f3); other values keep the current mode.
REQ-005 Ports phase_f1/phase_f2/phase_f3  in  32 each  phase samples.
REQ-006 Ports phase_en_f1/phase_en_f2/phase_en_f3  in  1 each  sample-valid strobes, one sample per high cycle.
REQ-007 Port pcie_ready  in  1  downstream accepts the word when pcie_valid && pcie_ready.
REQ-008 Port pcie_data  out  128  packed word.
REQ-009 Port pcie_valid  out  1  word valid; data held stable until accepted.
REQ-010 Port ovf_flags  out  3  sticky per-channel overflow, bit0 = f1.
REQ-011 Port cur_mode  out  1  active mode, 0 = single, 1 = triple.

Function
REQ-012 Packing: each channel SHALL shift a sample in at [31:0] on its enable, older samples moving up; the first sample of a word ends in [127:96].
REQ-013 The 4th sample SHALL complete a word; the word enters that channel's buffer the next cycle, and the packer count wraps to 0 with no lost sample.
REQ-014 In single mode only f1 SHALL be packed; phase_en_f2/f3 are ignored and channels 2/3 stay empty.
REQ-015 In triple mode the scheduler SHALL issue words in strict order f1,f2,f3,f1,...; it waits on the current channel even when others have words available, which keeps host demux alignment.
REQ-016 Scheduler states: IDLE (no valid), SEND (pcie_valid=1, waiting on ready); the channel pointer advances only on handshake.
REQ-017 Latency: with the buffer empty, the scheduler in IDLE, and the channel's turn, a 4th-sample enable at cycle N SHALL give pcie_valid=1 at N+2.
REQ-018 Throughput: one word per cycle SHALL be sustained while pcie_ready=1 and the selected channel has data; a handshake and a new issue may occur in the same cycle.
REQ-019 Buffer full: if a word completes while the channel buffer holds BUF_DEPTH words and no pop occurs that cycle, the new word SHALL be dropped and the channel's ovf_flags bit set.
REQ-020 Simultaneous push and pop on a full buffer SHALL succeed without overflow.
REQ-021 Mode change: a new freq_mode value SHALL be applied only when the output is idle or handshaking that cycle. On apply: packers and buffers clear, pointer returns to f1, ovf_flags clear.
REQ-022 A pending mode change SHALL NOT abort a word held on pcie_valid.
REQ-023 pcie_data SHALL NOT change while pcie_valid=1 and pcie_ready=0.

Reset
REQ-024 When rst=1 at a clock edge: pcie_data=0, pcie_valid=0, ovf_flags=0, cur_mode=0, all packer counts 0, buffers empty, pointer=f1, state IDLE.
REQ-025 Reset mid-transfer SHALL discard the held word and all partial words; no valid is asserted in the cycle after reset deasserts.

Structure
REQ-026 Shared package phase_sched_pkg SHALL hold MODE_SINGLE=0, MODE_TRIPLE=1, the channel-index enumeration, and the SAMPLES_PER_WORD/BUF_DEPTH defaults.
REQ-027 Sub-module phase_word_packer (shift packer, 2-bit count, BUF_DEPTH word FIFO, overflow flag) SHALL be instantiated three times; the scheduler FSM and mode control live in the top.

Verification
REQ-028 Single mode with pcie_ready=1: f1 samples 0x1,0x2,0x3,0x4 on consecutive cycles -> pcie_data=0x00000001_00000002_00000003_00000004 with valid two cycles after the 4th enable.
REQ-029 Triple mode: 4 samples each on f1=0xA*, f2=0xB*, f3=0xC*, with f3 completing first -> output order f1,f2,f3 words.
REQ-030 Backpressure: pcie_ready=0 for 10 cycles while valid -> data stable; the 3rd completed f1 word is dropped and ovf_flags=3'b001; the first two words are then delivered intact.
REQ-031 freq_mode 0->1 while valid and ready=0 -> the held word is delivered after ready rises, then the flush occurs and cur_mode=1; freq_mode=5 -> no change.
REQ-032 rst asserted one cycle mid-word with 2 samples packed -> all outputs 0, and the next 4 samples form a clean word.

Source files
------------

// File: rtl/phase_sched_pkg.sv
// Shared constants and types for the phase-sample PCIe scheduler.
// Holds mode encodings, channel indices, sizing defaults and the channel rotation helper.
package phase_sched_pkg;

   localparam int SAMPLES_PER_WORD_DFLT = 4;
   localparam int BUF_DEPTH_DFLT        = 2;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_TRIPLE = 1'b1;

   typedef enum logic [1:0] {
      CH_F1 = 2'd0,
      CH_F2 = 2'd1,
      CH_F3 = 2'd2
   } ch_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   function automatic ch_e ch_next(input ch_e c);
      case (c)
         CH_F1:   return CH_F2;
         CH_F2:   return CH_F3;
         default: return CH_F1;
      endcase
   endfunction

endpackage

// File: rtl/phase_word_packer.sv
// Per-channel shift packer feeding a small word FIFO; a completed word is written the same edge it completes.
// Head is popped on handshake; a word completing into a full FIFO with no pop is dropped and sets sticky ovf.
module phase_word_packer
   import phase_sched_pkg::*;
#(
   parameter int SAMPLES_PER_WORD = SAMPLES_PER_WORD_DFLT,
   parameter int BUF_DEPTH        = BUF_DEPTH_DFLT
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          en,
   input  logic [31:0]                   sample,
   input  logic                          pop,
   output logic [32*SAMPLES_PER_WORD-1:0] head,
   output logic [32*SAMPLES_PER_WORD-1:0] second,
   output logic                          has1,
   output logic                          has2,
   output logic                          ovf
);
   localparam int WW = 32 * SAMPLES_PER_WORD;
   localparam int CW = (SAMPLES_PER_WORD > 2) ? $clog2(SAMPLES_PER_WORD) : 1;
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int NW = $clog2(BUF_DEPTH + 1);

   logic [WW-1:0] shreg;
   logic [WW-1:0] word_done;
   logic [CW-1:0] cnt;
   logic [WW-1:0] mem [BUF_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [NW-1:0] fill;
   logic          done;
   logic          full;
   logic          push;
   logic          pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign word_done = {shreg[WW-33:0], sample};
   assign done      = en && (cnt == CW'(SAMPLES_PER_WORD - 1));
   assign full      = (fill == NW'(BUF_DEPTH));
   // A pop in the same cycle frees the slot the completing word lands in.
   assign push      = done && (!full || pop);
   assign pop_ok    = pop && (fill != '0);

   assign head   = mem[rd_ptr];
   assign second = mem[ptr_inc(rd_ptr)];
   assign has1   = (fill != '0);
   assign has2   = (32'(fill) >= 2);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word_done;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         shreg  <= '0;
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         ovf    <= 1'b0;
      end else begin
         if (en) begin
            shreg <= word_done;
            cnt   <= done ? '0 : cnt + 1'b1;
         end
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop_ok})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
         if (done && !push) ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/phase_pcie_scheduler.sv
// Packs up to three phase streams into 128-bit words and issues them in strict f1,f2,f3 order.
// Word valid two cycles after its last sample; data held while pcie_ready is low, one word per cycle when ready.
module phase_pcie_scheduler
   import phase_sched_pkg::*;
#(
   parameter int SAMPLES_PER_WORD = SAMPLES_PER_WORD_DFLT,
   parameter int BUF_DEPTH        = BUF_DEPTH_DFLT
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [2:0]                     freq_mode,
   input  logic [31:0]                    phase_f1,
   input  logic [31:0]                    phase_f2,
   input  logic [31:0]                    phase_f3,
   input  logic                           phase_en_f1,
   input  logic                           phase_en_f2,
   input  logic                           phase_en_f3,
   input  logic                           pcie_ready,
   output logic [32*SAMPLES_PER_WORD-1:0] pcie_data,
   output logic                           pcie_valid,
   output logic [2:0]                     ovf_flags,
   output logic                           cur_mode
);
   localparam int WW = 32 * SAMPLES_PER_WORD;

   logic [31:0]   smp    [3];
   logic [WW-1:0] head   [3];
   logic [WW-1:0] second [3];
   logic [2:0]    en_ch;
   logic [2:0]    pop;
   logic [2:0]    has1;
   logic [2:0]    has2;

   state_e        state;
   ch_e           ptr;
   ch_e           nxt;
   ch_e           cand;
   logic          cand_ok;
   logic [WW-1:0] cand_dat;
   logic          hs;
   logic          mode_req;
   logic          apply;

   assign smp[0] = phase_f1;
   assign smp[1] = phase_f2;
   assign smp[2] = phase_f3;
   assign en_ch  = {phase_en_f3 && (cur_mode == MODE_TRIPLE),
                    phase_en_f2 && (cur_mode == MODE_TRIPLE),
                    phase_en_f1};

   assign hs       = pcie_valid && pcie_ready;
   assign mode_req = ((freq_mode == 3'd0) && (cur_mode == MODE_TRIPLE)) ||
                     ((freq_mode == 3'd1) && (cur_mode == MODE_SINGLE));
   // Never abort a held word: switch only when idle or on the accepting edge.
   assign apply    = mode_req && (!pcie_valid || hs);

   for (genvar g = 0; g < 3; g++) begin : g_ch
      assign pop[g] = hs && (ptr == ch_e'(g));
      phase_word_packer #(
         .SAMPLES_PER_WORD (SAMPLES_PER_WORD),
         .BUF_DEPTH        (BUF_DEPTH)
      ) u_packer (
         .clk    (clk),
         .rst    (rst),
         .clr    (apply),
         .en     (en_ch[g]),
         .sample (smp[g]),
         .pop    (pop[g]),
         .head   (head[g]),
         .second (second[g]),
         .has1   (has1[g]),
         .has2   (has2[g]),
         .ovf    (ovf_flags[g])
      );
   end

   // On a handshake the next word comes from the next channel, or the word behind the head in single mode.
   always_comb begin
      nxt      = (cur_mode == MODE_TRIPLE) ? ch_next(ptr) : CH_F1;
      cand     = ptr;
      cand_ok  = has1[ptr];
      cand_dat = head[ptr];
      if (state == S_SEND) begin
         cand = nxt;
         if (nxt == ptr) begin
            cand_ok  = has2[ptr];
            cand_dat = second[ptr];
         end else begin
            cand_ok  = has1[nxt];
            cand_dat = head[nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         ptr        <= CH_F1;
         pcie_valid <= 1'b0;
         pcie_data  <= '0;
         cur_mode   <= MODE_SINGLE;
      end else if (apply) begin
         state      <= S_IDLE;
         ptr        <= CH_F1;
         pcie_valid <= 1'b0;
         cur_mode   <= freq_mode[0];
      end else begin
         case (state)
            S_IDLE: begin
               if (cand_ok) begin
                  state      <= S_SEND;
                  pcie_valid <= 1'b1;
                  pcie_data  <= cand_dat;
               end
            end
            S_SEND: begin
               if (hs) begin
                  ptr <= cand;
                  if (cand_ok) begin
                     pcie_data <= cand_dat;
                  end else begin
                     state      <= S_IDLE;
                     pcie_valid <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
